// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if -- signal bundle between the fetch PC unit and its
// surroundings (PC+4 adder, hazard unit, ID redirect logic, CP0, IM).
//
// Signals:
//   pc_plus4         sequential next address from the PC+4 adder
//   stall            hazard-unit freeze of the fetch stage
//   redirect_valid   ID-stage branch-taken / jump request
//   redirect_target  target address for the redirect
//   exc_req          exception / interrupt entry request
//   pc               current fetch address
//   redirect_pending a redirect that arrived during a stall is buffered
//   redirect_ack     redirect accepted this cycle (applied or buffered)
//   fetch_adel       fetch address error flag (FETCH_PC_ALIGN_CHECK_EN only)
//
// Modports: slave = the PC unit, master = the surrounding pipeline.

interface fetch_pc_unit_if;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic [31:0] pc;
    logic        redirect_pending;
    logic        redirect_ack;
`ifdef FETCH_PC_ALIGN_CHECK_EN
    logic        fetch_adel;
`endif

    modport slave (
        input  pc_plus4,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  exc_req,
        output pc,
        output redirect_pending,
`ifdef FETCH_PC_ALIGN_CHECK_EN
        output fetch_adel,
`endif
        output redirect_ack
    );

    modport master (
        output pc_plus4,
        output stall,
        output redirect_valid,
        output redirect_target,
        output exc_req,
        input  pc,
        input  redirect_pending,
`ifdef FETCH_PC_ALIGN_CHECK_EN
        input  fetch_adel,
`endif
        input  redirect_ack
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit -- program-counter register and next-PC selector for the
// fetch stage.
//
// Selects the next fetch address from, highest priority first: exception
// entry, a live redirect (no stall), a buffered redirect once the stall
// clears, a held PC under stall, and the sequential pc_plus4 from the
// external adder. A redirect presented while stalled is captured into a
// single-entry buffer (state PEND) so the ID stage can drop its request
// after the ack.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  asynchronous active-low reset (0 = reset asserted)
//   bus    fetch_pc_unit_if.slave (see interface for signal list)
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   EXC_VECTOR  PC value loaded on exception entry
//
// Optional feature (macro FETCH_PC_ALIGN_CHECK_EN): adds bus.fetch_adel, a
// flag registered alongside pc that is set when the loaded pc is not word
// aligned or lies outside 32'h0000_3000..32'h0000_6FFC. The pc is loaded
// regardless; raising the exception is CP0's decision.

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic           clk,
    input  logic           reset,
    fetch_pc_unit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] buf_r;
    logic [31:0] buf_nxt_s;

`ifdef FETCH_PC_ALIGN_CHECK_EN
    logic        adel_r;

    // Address error: misaligned, or outside the legal instruction window.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        fetch_addr_bad = (addr[1:0] != 2'b00) ||
                         (addr < 32'h0000_3000) ||
                         (addr > 32'h0000_6FFC);
    endfunction
`endif

    // Next-PC / next-state selection, priority ordered.
    always_comb begin
        pc_nxt_s    = pc_r;
        buf_nxt_s   = buf_r;
        state_nxt_s = state_r;
        if (bus.exc_req) begin
            // Exception ignores stall; a buffered target is dropped by
            // returning to RUN (the stale buffer contents are never used).
            pc_nxt_s    = EXC_VECTOR;
            state_nxt_s = ST_RUN;
        end else if (bus.redirect_valid && !bus.stall) begin
            pc_nxt_s    = bus.redirect_target;
            state_nxt_s = ST_RUN;
        end else if (bus.redirect_valid && bus.stall) begin
            // Newer redirect overwrites any previously buffered target.
            buf_nxt_s   = bus.redirect_target;
            state_nxt_s = ST_PEND;
        end else begin
            case (state_r)
                ST_PEND: begin
                    if (!bus.stall) begin
                        pc_nxt_s    = buf_r;
                        state_nxt_s = ST_RUN;
                    end else begin
                        pc_nxt_s    = pc_r;
                    end
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        pc_nxt_s = bus.pc_plus4;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // PC, redirect buffer and state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r    <= RESET_PC;
            buf_r   <= 32'h0000_0000;
            state_r <= ST_RUN;
        end else begin
            pc_r    <= pc_nxt_s;
            buf_r   <= buf_nxt_s;
            state_r <= state_nxt_s;
        end
    end

`ifdef FETCH_PC_ALIGN_CHECK_EN
    // Address-error flag, registered in step with the pc it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adel_r <= 1'b0;
        end else begin
            adel_r <= fetch_addr_bad(pc_nxt_s);
        end
    end

    assign bus.fetch_adel = adel_r;
`endif

    assign bus.pc               = pc_r;
    assign bus.redirect_pending = (state_r == ST_PEND);
    // An exception in the same cycle swallows the redirect: no ack.
    assign bus.redirect_ack     = bus.redirect_valid & ~bus.exc_req;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit -- directed self-checking bench for fetch_pc_unit.
// The PC+4 adder is modelled in the bench; every expected value is a
// hand-computed constant. Inputs change 1 time unit after a rising edge and
// outputs are checked 2 units after it, well clear of the clock edge.

module tb_fetch_pc_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_pc_unit_if bus ();

    // Model PC+4 adder (32-bit, wraps naturally).
    assign bus.pc_plus4 = bus.pc + 32'd4;

    fetch_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;
        bus.exc_req = 1'b0;
        repeat (3) step();
        #1;
        n_checks++; if (bus.pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0000_3000); end
        n_checks++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", bus.redirect_pending); end
        n_checks++; if (bus.redirect_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", bus.redirect_ack); end
`ifdef FETCH_PC_ALIGN_CHECK_EN
        n_checks++; if (bus.fetch_adel !== 1'b0) begin n_fail++; $display("FAIL reset_adel got=%b exp=0", bus.fetch_adel); end
`endif
        reset = 1'b1;
        #1;
        n_checks++; if (bus.pc !== 32'h0000_3000) begin n_fail++; $display("FAIL release_pc got=%h exp=%h", bus.pc, 32'h0000_3000); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h0000_3004;
        exp_seq[1] = 32'h0000_3008;
        exp_seq[2] = 32'h0000_300C;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            n_checks++; if (bus.pc !== exp_seq[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc, exp_seq[i]); end
        end
    endtask

    task automatic test_redirect();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_3100;
        #1;
        n_checks++; if (bus.redirect_ack !== 1'b1) begin n_fail++; $display("FAIL redir_ack got=%b exp=1", bus.redirect_ack); end
        step();
        bus.redirect_valid = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 32'h0000_3100) begin n_fail++; $display("FAIL redir_pc got=%h exp=%h", bus.pc, 32'h0000_3100); end
        n_checks++; if (bus.redirect_ack !== 1'b0) begin n_fail++; $display("FAIL redir_ack_drop got=%b exp=0", bus.redirect_ack); end
`ifdef FETCH_PC_ALIGN_CHECK_EN
        n_checks++; if (bus.fetch_adel !== 1'b0) begin n_fail++; $display("FAIL redir_adel got=%b exp=0", bus.fetch_adel); end
`endif
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_3104) begin n_fail++; $display("FAIL redir_next got=%h exp=%h", bus.pc, 32'h0000_3104); end
    endtask

    task automatic test_stall_buffer();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_3200;
        #1;
        n_checks++; if (bus.redirect_ack !== 1'b1) begin n_fail++; $display("FAIL buf_ack got=%b exp=1", bus.redirect_ack); end
        step();
        bus.redirect_valid = 1'b0;
        step();
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_3104) begin n_fail++; $display("FAIL buf_hold got=%h exp=%h", bus.pc, 32'h0000_3104); end
        n_checks++; if (bus.redirect_pending !== 1'b1) begin n_fail++; $display("FAIL buf_pending got=%b exp=1", bus.redirect_pending); end
        bus.stall = 1'b0;
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_3200) begin n_fail++; $display("FAIL buf_apply got=%h exp=%h", bus.pc, 32'h0000_3200); end
        n_checks++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL buf_clear got=%b exp=0", bus.redirect_pending); end
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_3204) begin n_fail++; $display("FAIL buf_next got=%h exp=%h", bus.pc, 32'h0000_3204); end
    endtask

    task automatic test_overwrite();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_3200;
        step();
        bus.redirect_target = 32'h0000_3300;
        step();
        bus.redirect_valid = 1'b0;
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_3204) begin n_fail++; $display("FAIL ovw_hold got=%h exp=%h", bus.pc, 32'h0000_3204); end
        bus.stall = 1'b0;
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_3300) begin n_fail++; $display("FAIL ovw_apply got=%h exp=%h", bus.pc, 32'h0000_3300); end
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_3304) begin n_fail++; $display("FAIL ovw_next got=%h exp=%h", bus.pc, 32'h0000_3304); end
    endtask

    task automatic test_exception();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_3200;
        step();
        bus.redirect_target = 32'h0000_3500;
        bus.exc_req = 1'b1;
        #1;
        n_checks++; if (bus.redirect_ack !== 1'b0) begin n_fail++; $display("FAIL exc_ack got=%b exp=0", bus.redirect_ack); end
        n_checks++; if (bus.redirect_pending !== 1'b1) begin n_fail++; $display("FAIL exc_pre_pending got=%b exp=1", bus.redirect_pending); end
        step();
        bus.exc_req = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 32'h0000_4180) begin n_fail++; $display("FAIL exc_pc got=%h exp=%h", bus.pc, 32'h0000_4180); end
        n_checks++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL exc_pending got=%b exp=0", bus.redirect_pending); end
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_4184) begin n_fail++; $display("FAIL exc_discard got=%h exp=%h", bus.pc, 32'h0000_4184); end
    endtask

    task automatic test_async_reset();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_3600;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        n_checks++; if (bus.redirect_pending !== 1'b1) begin n_fail++; $display("FAIL ares_pre_pending got=%b exp=1", bus.redirect_pending); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 32'h0000_3000) begin n_fail++; $display("FAIL ares_pc got=%h exp=%h", bus.pc, 32'h0000_3000); end
        n_checks++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL ares_pending got=%b exp=0", bus.redirect_pending); end
        step();
        reset = 1'b1;
        bus.stall = 1'b0;
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_3004) begin n_fail++; $display("FAIL ares_lost got=%h exp=%h", bus.pc, 32'h0000_3004); end
    endtask

    task automatic test_boundaries();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_load got=%h exp=%h", bus.pc, 32'hFFFF_FFFC); end
`ifdef FETCH_PC_ALIGN_CHECK_EN
        n_checks++; if (bus.fetch_adel !== 1'b1) begin n_fail++; $display("FAIL wrap_adel got=%b exp=1", bus.fetch_adel); end
`endif
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_zero got=%h exp=%h", bus.pc, 32'h0000_0000); end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_3102;
        step();
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b1;
        #1;
        n_checks++; if (bus.pc !== 32'h0000_3102) begin n_fail++; $display("FAIL unalign_pc got=%h exp=%h", bus.pc, 32'h0000_3102); end
`ifdef FETCH_PC_ALIGN_CHECK_EN
        n_checks++; if (bus.fetch_adel !== 1'b1) begin n_fail++; $display("FAIL unalign_adel got=%b exp=1", bus.fetch_adel); end
`endif
        // Exception entry overrides an active stall.
        bus.exc_req = 1'b1;
        step();
        bus.exc_req = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 32'h0000_4180) begin n_fail++; $display("FAIL exc_stall got=%h exp=%h", bus.pc, 32'h0000_4180); end
`ifdef FETCH_PC_ALIGN_CHECK_EN
        n_checks++; if (bus.fetch_adel !== 1'b0) begin n_fail++; $display("FAIL exc_adel got=%b exp=0", bus.fetch_adel); end
`endif
        step(); #1;
        n_checks++; if (bus.pc !== 32'h0000_4180) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", bus.pc, 32'h0000_4180); end
        bus.stall = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_buffer();
        test_overwrite();
        test_exception();
        test_async_reset();
        test_boundaries();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
